// File: rtl/cordic_fsm_pkg.sv
// Shared state encoding, variable indices and angle-region codes for the
// CORDIC control FSM.
package cordic_fsm_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD      = 4'd1,
        SETUP     = 4'd2,
        ADD_BEG   = 4'd3,
        ADD_WAIT  = 4'd4,
        ADD_ACK   = 4'd5,
        OUT_SEL   = 4'd6,
        OUT_LATCH = 4'd7,
        DONE      = 4'd8,
        ERR       = 4'd9
    } state_t;

    localparam logic [1:0] VAR_X = 2'd0;
    localparam logic [1:0] VAR_Y = 2'd1;
    localparam logic [1:0] VAR_Z = 2'd2;

    // Regions in which cos and sin trade places at the output.
    localparam logic [1:0] REGION_01 = 2'b01;
    localparam logic [1:0] REGION_10 = 2'b10;

    function automatic logic region_swaps(input logic [1:0] region);
        return (region == REGION_01) || (region == REGION_10);
    endfunction

endpackage

// File: rtl/cordic_counter.sv
// Saturating up-counter with synchronous load; holds at MAX instead of wrapping.
module cordic_counter #(
    parameter int W   = 5,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_max_tick,
    output logic         o_min_tick
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && !o_max_tick) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_max_tick = (r_cnt == W'(MAX));
    assign o_min_tick = (r_cnt == '0);

endmodule

// File: rtl/cordic_fsm_param.sv
// CORDIC control FSM: sequences X/Y/Z through N_ITER iterations on a shared
// add/subtract unit and flags a stalled unit as a timeout.
module cordic_fsm_param
    import cordic_fsm_pkg::*;
#(
    parameter int N_ITER  = 16,
    parameter int ITER_W  = 5,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beg_FSM_CORDIC,
    input  logic              ACK_FSM_CORDIC,
    input  logic              operation,
    input  logic              mode_in,
    input  logic [1:0]        shift_region_flag,
    input  logic              ready_add_subt,
    output logic              ready_CORDIC,
    output logic              err_timeout,
    output logic              busy,
    output logic              mode,
    output logic              beg_add_subt,
    output logic              ack_add_subt,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [1:0]        var_cnt,
    output logic              sel_mux_1,
    output logic [1:0]        sel_mux_2,
    output logic              sel_mux_3,
    output logic              enab_RB1,
    output logic              enab_RB2,
    output logic              enab_d_ff_Xn,
    output logic              enab_d_ff_Yn,
    output logic              enab_d_ff_Zn,
    output logic              enab_dff_shifted_x,
    output logic              enab_dff_shifted_y,
    output logic              enab_dff_LUT,
    output logic              enab_dff_sign,
    output logic              enab_dff5,
    output logic              enab_d_ff_out,
    output logic [3:0]        dbg_state
);

    state_t            r_state;
    state_t            w_next;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_mode;
    logic              r_sel3;
    logic              w_to_hit;
    logic              w_iter_load, w_iter_en, w_var_load, w_var_en;
    logic              w_iter_max, w_iter_min, w_var_max, w_var_min;
    logic [ITER_W-1:0] w_iter;
    logic [1:0]        w_var;
    logic              w_add_phase;

    cordic_counter #(.W(ITER_W), .MAX(N_ITER - 1)) u_iter_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_iter_load),
        .i_load_val ('0),
        .i_en       (w_iter_en),
        .o_cnt      (w_iter),
        .o_max_tick (w_iter_max),
        .o_min_tick (w_iter_min)
    );

    cordic_counter #(.W(2), .MAX(int'(VAR_Z))) u_var_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_var_load),
        .i_load_val (VAR_X),
        .i_en       (w_var_en),
        .o_cnt      (w_var),
        .o_max_tick (w_var_max),
        .o_min_tick (w_var_min)
    );

    // The wait counter is compared before incrementing, so ERR is entered on
    // the edge that ends the TIMEOUT-th cycle without ready.
    assign w_to_hit = (TIMEOUT != 0) && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_iter_load = 1'b0;
        w_iter_en   = 1'b0;
        w_var_load  = 1'b0;
        w_var_en    = 1'b0;
        case (r_state)
            IDLE:      if (beg_FSM_CORDIC) w_next = LOAD;
            LOAD: begin
                w_iter_load = 1'b1;
                w_var_load  = 1'b1;
                w_next      = SETUP;
            end
            SETUP:     w_next = ADD_BEG;
            ADD_BEG:   w_next = ADD_WAIT;
            ADD_WAIT: begin
                if (ready_add_subt) w_next = ADD_ACK;
                else if (w_to_hit)  w_next = ERR;
            end
            ADD_ACK: begin
                if (!w_var_max) begin
                    w_var_en = 1'b1;
                    w_next   = ADD_BEG;
                end else if (!w_iter_max) begin
                    w_var_load = 1'b1;
                    w_iter_en  = 1'b1;
                    w_next     = SETUP;
                end else begin
                    w_next = OUT_SEL;
                end
            end
            OUT_SEL:   w_next = OUT_LATCH;
            OUT_LATCH: w_next = DONE;
            DONE:      if (ACK_FSM_CORDIC) w_next = IDLE;
            ERR:       if (ACK_FSM_CORDIC) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_mode   <= 1'b0;
            r_sel3   <= 1'b0;
        end else begin
            if (r_state == ADD_BEG) begin
                r_to_cnt <= '0;
            end else if ((r_state == ADD_WAIT) && !ready_add_subt && !(&r_to_cnt)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state == LOAD) begin
                r_mode <= mode_in;
            end
            if ((r_state == ADD_ACK) && (w_next == OUT_SEL)) begin
                r_sel3 <= operation ^ region_swaps(shift_region_flag);
            end
        end
    end

    assign w_add_phase = (r_state == ADD_BEG) || (r_state == ADD_WAIT) || (r_state == ADD_ACK);

    always_comb begin
        busy               = (r_state != IDLE);
        ready_CORDIC       = (r_state == DONE);
        err_timeout        = (r_state == ERR);
        beg_add_subt       = (r_state == ADD_BEG);
        ack_add_subt       = (r_state == ADD_ACK);
        enab_RB1           = (r_state == LOAD);
        enab_RB2           = (r_state == SETUP);
        enab_dff_shifted_x = (r_state == SETUP);
        enab_dff_shifted_y = (r_state == SETUP);
        enab_dff_LUT       = (r_state == SETUP);
        enab_dff_sign      = (r_state == SETUP);
        sel_mux_1          = (r_state == SETUP) && !w_iter_min;
        sel_mux_2          = w_add_phase ? w_var : 2'd0;
        enab_d_ff_Xn       = (r_state == ADD_ACK) && w_var_min;
        enab_d_ff_Yn       = (r_state == ADD_ACK) && (w_var == VAR_Y);
        enab_d_ff_Zn       = (r_state == ADD_ACK) && (w_var == VAR_Z);
        enab_dff5          = (r_state == OUT_SEL);
        enab_d_ff_out      = (r_state == OUT_LATCH);
        sel_mux_3          = ((r_state == OUT_SEL) || (r_state == OUT_LATCH)) && r_sel3;
    end

    assign iter_cnt  = w_iter;
    assign var_cnt   = w_var;
    assign mode      = r_mode;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cordic_fsm_param.sv
// Self-checking bench for cordic_fsm_param: table-driven runs with a
// behavioural add/subt responder, plus reset, timeout and handshake sequences.
module tb_cordic_fsm_param;
  import cordic_fsm_pkg::*;

  localparam int N_ITER  = 16;
  localparam int ITER_W  = 5;
  localparam int TIMEOUT = 10;
  localparam int TO_W    = 8;
  localparam int NEVER   = 100000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              beg_FSM_CORDIC, ACK_FSM_CORDIC, operation, mode_in, ready_add_subt;
  logic [1:0]        shift_region_flag;
  logic              ready_CORDIC, err_timeout, busy, mode, beg_add_subt, ack_add_subt;
  logic [ITER_W-1:0] iter_cnt;
  logic [1:0]        var_cnt, sel_mux_2;
  logic              sel_mux_1, sel_mux_3;
  logic              enab_RB1, enab_RB2, enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn;
  logic              enab_dff_shifted_x, enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign;
  logic              enab_dff5, enab_d_ff_out;
  logic [3:0]        dbg_state;

  cordic_fsm_param #(.N_ITER(N_ITER), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .beg_FSM_CORDIC(beg_FSM_CORDIC), .ACK_FSM_CORDIC(ACK_FSM_CORDIC),
    .operation(operation), .mode_in(mode_in), .shift_region_flag(shift_region_flag),
    .ready_add_subt(ready_add_subt), .ready_CORDIC(ready_CORDIC), .err_timeout(err_timeout),
    .busy(busy), .mode(mode), .beg_add_subt(beg_add_subt), .ack_add_subt(ack_add_subt),
    .iter_cnt(iter_cnt), .var_cnt(var_cnt), .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2),
    .sel_mux_3(sel_mux_3), .enab_RB1(enab_RB1), .enab_RB2(enab_RB2),
    .enab_d_ff_Xn(enab_d_ff_Xn), .enab_d_ff_Yn(enab_d_ff_Yn), .enab_d_ff_Zn(enab_d_ff_Zn),
    .enab_dff_shifted_x(enab_dff_shifted_x), .enab_dff_shifted_y(enab_dff_shifted_y),
    .enab_dff_LUT(enab_dff_LUT), .enab_dff_sign(enab_dff_sign), .enab_dff5(enab_dff5),
    .enab_d_ff_out(enab_d_ff_out), .dbg_state(dbg_state)
  );

  wire [27:0] all_outs = {ready_CORDIC, err_timeout, busy, mode, beg_add_subt, ack_add_subt,
                          iter_cnt, var_cnt, sel_mux_1, sel_mux_2, sel_mux_3, enab_RB1, enab_RB2,
                          enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn, enab_dff_shifted_x,
                          enab_dff_shifted_y, enab_dff_LUT, enab_dff_sign, enab_dff5, enab_d_ff_out};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: each variable costs BEG + (d+1) WAIT + ACK cycles, each
  // iteration adds SETUP, plus LOAD before and OUT_SEL/OUT_LATCH after.
  function automatic int ref_latency(input int d);
    return 1 + N_ITER * (1 + 3 * (2 + (d + 1))) + 2;
  endfunction

  function automatic logic ref_sel3(input logic op, input logic [1:0] region);
    return op ^ ((region == 2'b01) || (region == 2'b10));
  endfunction

  // ---------------- add/subt responder + monitor ----------------
  bit   add_hold, add_pend;
  int   add_delay, add_rem;
  logic exp_sel3_cur;
  int   n_beg, n_ack, n_x, n_y, n_z, n_setup, n_rb1, n_dff5, n_out;
  int   n_bad_sel1, n_bad_sel2, n_bad_sel3, n_bad_onehot, n_err_en;

  task automatic clear_counts();
    n_beg = 0; n_ack = 0; n_x = 0; n_y = 0; n_z = 0; n_setup = 0; n_rb1 = 0;
    n_dff5 = 0; n_out = 0; n_bad_sel1 = 0; n_bad_sel2 = 0; n_bad_sel3 = 0;
    n_bad_onehot = 0; n_err_en = 0; add_pend = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (beg_add_subt) begin
        if (sel_mux_2 != 2'(n_beg % 3) || int'(iter_cnt) != n_beg / 3) n_bad_sel2++;
        n_beg++;
        add_pend = 1;
        add_rem  = add_delay;
        if (!add_hold) ready_add_subt = 1'b0;
      end else if (ack_add_subt) begin
        if (sel_mux_2 != 2'(n_ack % 3)) n_bad_sel2++;
        if ({enab_d_ff_Xn, enab_d_ff_Yn, enab_d_ff_Zn} != (3'b100 >> (n_ack % 3))) n_bad_onehot++;
        n_x += int'(enab_d_ff_Xn);
        n_y += int'(enab_d_ff_Yn);
        n_z += int'(enab_d_ff_Zn);
        n_ack++;
        add_pend = 0;
        if (!add_hold) ready_add_subt = 1'b0;
      end else if (add_pend && !err_timeout) begin
        if (sel_mux_2 != 2'((n_beg - 1) % 3)) n_bad_sel2++;
        if (!add_hold) begin
          if (add_rem == 0) ready_add_subt = 1'b1;
          else add_rem--;
        end
      end
      if (enab_RB1) n_rb1++;
      if (enab_RB2) begin
        if (sel_mux_1 != (n_setup != 0) || int'(iter_cnt) != n_setup) n_bad_sel1++;
        if (!(enab_dff_shifted_x && enab_dff_shifted_y && enab_dff_LUT && enab_dff_sign)) n_bad_sel1++;
        n_setup++;
      end
      if (enab_dff5) begin
        n_dff5++;
        if (sel_mux_3 != exp_sel3_cur) n_bad_sel3++;
      end
      if (enab_d_ff_out) begin
        n_out++;
        if (sel_mux_3 != exp_sel3_cur) n_bad_sel3++;
      end
      if (err_timeout && (enab_d_ff_Xn || enab_d_ff_Yn || enab_d_ff_Zn || enab_dff5 || enab_d_ff_out))
        n_err_en++;
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic       op;
    logic [1:0] region;
    logic       mode_in;
    logic       hold;
    int         delay;
    logic       sel3;
    int         lat;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    int n;
    int held;
    clear_counts();
    add_hold = v.hold; add_delay = v.delay; ready_add_subt = v.hold;
    operation = v.op; shift_region_flag = v.region; mode_in = v.mode_in;
    exp_sel3_cur = v.sel3;
    exp_q.push_back(16'(v.lat));
    @(negedge clk); beg_FSM_CORDIC = 1'b1;
    @(negedge clk); beg_FSM_CORDIC = 1'b0;
    n = 0;
    while (!ready_CORDIC && !err_timeout && n < 2000) begin
      n++;
      if (n == 3) mode_in = ~v.mode_in;
      if (n == 20) begin beg_FSM_CORDIC = 1'b1; ACK_FSM_CORDIC = 1'b1; end
      if (n == 21) begin beg_FSM_CORDIC = 1'b0; ACK_FSM_CORDIC = 1'b0; end
      @(negedge clk);
    end
    check({tag, "_latency"}, n, int'(exp_q.pop_front()));
    check({tag, "_ready"}, int'(ready_CORDIC), 1);
    held = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready_CORDIC) held++;
    end
    check({tag, "_ready_held"}, held, 20);
    check({tag, "_mode"}, int'(mode), int'(v.mode_in));
    check({tag, "_beg_pulses"}, n_beg, 3 * N_ITER);
    check({tag, "_ack_pulses"}, n_ack, 3 * N_ITER);
    check({tag, "_xn"}, n_x, N_ITER);
    check({tag, "_yn"}, n_y, N_ITER);
    check({tag, "_zn"}, n_z, N_ITER);
    check({tag, "_setups"}, n_setup, N_ITER);
    check({tag, "_rb1"}, n_rb1, 1);
    check({tag, "_out_enables"}, n_dff5 + n_out, 2);
    check({tag, "_sel1"}, n_bad_sel1, 0);
    check({tag, "_sel2"}, n_bad_sel2, 0);
    check({tag, "_sel3"}, n_bad_sel3, 0);
    check({tag, "_onehot"}, n_bad_onehot, 0);
    ACK_FSM_CORDIC = 1'b1; beg_FSM_CORDIC = 1'b1;
    @(negedge clk);
    check({tag, "_idle_after_ack"}, int'(busy), 0);
    check({tag, "_ready_cleared"}, int'(ready_CORDIC), 0);
    ACK_FSM_CORDIC = 1'b0; beg_FSM_CORDIC = 1'b0;
    @(negedge clk);
    check({tag, "_beg_with_ack_ignored"}, int'(busy), 0);
  endtask

  task automatic run_timeout();
    int k;
    int held;
    clear_counts();
    add_hold = 0; add_delay = NEVER; ready_add_subt = 1'b0;
    @(negedge clk); beg_FSM_CORDIC = 1'b1;
    @(negedge clk); beg_FSM_CORDIC = 1'b0;
    k = 0;
    while (!beg_add_subt && k < 20) begin @(negedge clk); k++; end
    check("to_first_beg", int'(beg_add_subt), 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!err_timeout && k < 100);
    check("to_cycles", k, TIMEOUT + 1);
    check("to_ready_low", int'(ready_CORDIC), 0);
    check("to_busy", int'(busy), 1);
    held = 0;
    repeat (5) begin
      @(negedge clk);
      if (err_timeout && !ready_CORDIC) held++;
    end
    check("to_err_held", held, 5);
    check("to_no_ack", n_ack, 0);
    check("to_no_enables", n_err_en, 0);
    ACK_FSM_CORDIC = 1'b1;
    @(negedge clk);
    ACK_FSM_CORDIC = 1'b0;
    check("to_err_cleared", int'(err_timeout), 0);
    check("to_idle", int'(busy), 0);
    add_pend = 0;
  endtask

  task automatic run_reset_mid();
    int k;
    int begs;
    clear_counts();
    add_hold = 0; add_delay = 3; ready_add_subt = 1'b0;
    operation = 1'b0; shift_region_flag = 2'b00; mode_in = 1'b1;
    @(negedge clk); beg_FSM_CORDIC = 1'b1;
    @(negedge clk); beg_FSM_CORDIC = 1'b0;
    begs = 0; k = 0;
    while (begs < 5 * 3 + 1 && k < 1000) begin
      if (beg_add_subt) begin
        begs++;
        if (begs == 5 * 3 + 1) break;
      end
      @(negedge clk); k++;
    end
    @(negedge clk);
    check("rst_iter_before", int'(iter_cnt), 5);
    check("rst_busy_before", int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("rst_outputs_zero", int'(all_outs), 0);
    check("rst_state_idle", int'(dbg_state == IDLE), 1);
    @(negedge clk);
    reset = 1'b0; add_pend = 0; ready_add_subt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stays_idle", int'(busy), 0);
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[9];

  initial begin
    reset = 1'b1;
    beg_FSM_CORDIC = 1'b0; ACK_FSM_CORDIC = 1'b0; operation = 1'b0; mode_in = 1'b0;
    shift_region_flag = 2'b00; ready_add_subt = 1'b0;
    add_hold = 0; add_delay = 0; add_rem = 0; exp_sel3_cur = 1'b0;
    clear_counts();
    #12;
    check("reset_outputs_zero", int'(all_outs), 0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'(busy), 0);

    //          op    region  mode  hold  d  sel3  latency
    vecs[0] = '{1'b0, 2'b00, 1'b0, 1'b1, 0, 1'b0, 163};
    vecs[1] = '{1'b0, 2'b01, 1'b1, 1'b1, 0, 1'b1, 163};
    vecs[2] = '{1'b1, 2'b10, 1'b0, 1'b0, 0, 1'b0, 163};
    vecs[3] = '{1'b1, 2'b00, 1'b1, 1'b0, 7, 1'b1, 499};
    vecs[4] = '{1'b0, 2'b11, 1'b0, 1'b0, 9, 1'b0, 595};
    for (int i = 5; i < 9; i++) begin
      vecs[i].op      = 1'($urandom_range(0, 1));
      vecs[i].region  = 2'($urandom_range(0, 3));
      vecs[i].mode_in = 1'($urandom_range(0, 1));
      vecs[i].hold    = 1'b0;
      vecs[i].delay   = $urandom_range(0, 9);
      vecs[i].sel3    = ref_sel3(vecs[i].op, vecs[i].region);
      vecs[i].lat     = ref_latency(vecs[i].delay);
    end

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    run_timeout();
    run_reset_mid();
    run_vec("after_reset", vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
